shared_reg_arbiter: RTL and testbench



---
 rtl/shared_reg_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shared_reg_arbiter
//  Purpose  : One WIDTH-bit D-type register shared by NREQ requesters.
//             Round-robin arbitration with a request / grant / ack handshake.
//             Each tenure lasts at most MAX_HOLD grant cycles. Only the
//             current owner may write the register.
//  Ports    :
//    clk    in   1           rising-edge clock
//    reset  in   1           synchronous active-high reset
//    req    in   NREQ        per-requester level request, held until done
//    wr     in   NREQ        per-requester write strobe (owner only)
//    wdata  in   NREQ*WIDTH  packed write data, lane i = [i*WIDTH +: WIDTH]
//    gnt    out  NREQ        registered one-hot grant, zero when no owner
//    ack    out  NREQ        registered one-cycle write-commit pulse
//    q      out  WIDTH       stored register value
//    qbar   out  WIDTH       bitwise complement of q
//    busy   out  1           high while a requester owns the register
//  Revision : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD);

  localparam logic [PW-1:0] c_PTR_RESET = PW'(NREQ - 1);
  localparam logic [HW-1:0] c_HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic [WIDTH-1:0]  r_q;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [HW-1:0]     r_hold;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic [NREQ-1:0]   w_ack_nxt;
  logic [WIDTH-1:0]  w_q_nxt;
  logic [PW-1:0]     w_ptr_nxt;
  logic [PW-1:0]     w_owner_nxt;
  logic [HW-1:0]     w_hold_nxt;

  // Arbitration result
  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_idx;

  // Write data split into per-requester lanes
  logic [WIDTH-1:0]  w_lane [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign w_lane[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  // --------------------------------------------------------------------------
  // Round-robin search: first asserted req at ptr+1, ptr+2, ... mod NREQ.
  // Searching up to k = NREQ lets the previous owner win only when it is
  // the sole requester.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = PW'((32'(r_ptr) + 32'(k)) % 32'(NREQ));
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ack_nxt   = '0;
    w_q_nxt     = r_q;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_OWN;
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_owner_nxt = w_win;
          w_hold_nxt  = '0;
        end
      end

      S_OWN: begin
        if (!req[r_owner]) begin
          // Owner is done; a write strobe alongside a dropped req is ignored.
          w_state_nxt = S_GAP;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_owner;
        end else begin
          if (wr[r_owner]) begin
            w_q_nxt   = w_lane[r_owner];
            w_ack_nxt = NREQ'(1) << r_owner;
          end
          if (r_hold == c_HOLD_LAST) begin
            // Forced release; a write in this final cycle still commits.
            w_state_nxt = S_GAP;
            w_gnt_nxt   = '0;
            w_ptr_nxt   = r_owner;
          end else begin
            w_hold_nxt = r_hold + HW'(1);
          end
        end
      end

      S_GAP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_q     <= '0;
      r_ptr   <= c_PTR_RESET;
      r_owner <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
      r_q     <= w_q_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign ack  = r_ack;
  assign q    = r_q;
  assign qbar = ~r_q;
  assign busy = (r_state == S_OWN);

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shared_reg_arbiter
//  Purpose  : Scoreboard bench for shared_reg_arbiter. A stimulus process
//             drives directed and random traffic and pushes the reference
//             model's expected outputs; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shared_reg_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       wr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic                  busy;

  shared_reg_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .wr   (wr),
    .wdata(wdata),
    .gnt  (gnt),
    .ack  (ack),
    .q    (q),
    .qbar (qbar),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] q;
    logic             busy;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // --------------------------------------------------------------------------
  // Reference model: who owns the register, how many grant cycles it has
  // used, how many idle cycles remain before the next arbitration, and
  // whose turn it was last.
  // --------------------------------------------------------------------------
  int               m_owner;   // -1 when nobody owns
  int               m_used;
  int               m_wait;
  int               m_last;
  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  m_ack;

  task automatic model_step(input logic r, input logic [NREQ-1:0] rq,
                            input logic [NREQ-1:0] w,
                            input logic [NREQ*WIDTH-1:0] wd);
    exp_t e;
    m_ack = '0;
    if (r) begin
      m_owner = -1;
      m_used  = 0;
      m_wait  = 0;
      m_last  = NREQ - 1;
      m_q     = '0;
    end else if (m_owner >= 0) begin
      if (!rq[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_wait  = 1;
      end else begin
        if (w[m_owner]) begin
          m_q             = wd[m_owner*WIDTH +: WIDTH];
          m_ack[m_owner]  = 1'b1;
        end
        m_used++;
        if (m_used == MAX_HOLD) begin
          m_last  = m_owner;
          m_owner = -1;
          m_wait  = 1;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (m_owner < 0 && rq[c]) begin
          m_owner = c;
          m_used  = 0;
        end
      end
    end
    e.gnt  = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    e.ack  = m_ack;
    e.q    = m_q;
    e.busy = (m_owner >= 0);
    sb.push_back(e);
  endtask

  // One clock of stimulus: inputs change on the falling edge.
  task automatic cyc(input logic r, input logic [NREQ-1:0] rq,
                     input logic [NREQ-1:0] w, input logic [NREQ*WIDTH-1:0] wd);
    @(negedge clk);
    reset = r;
    req   = rq;
    wr    = w;
    wdata = wd;
    model_step(r, rq, w, wd);
  endtask

  function automatic logic [NREQ*WIDTH-1:0] lane(input int i, input logic [WIDTH-1:0] v);
    logic [NREQ*WIDTH-1:0] t;
    t = '0;
    t[i*WIDTH +: WIDTH] = v;
    return t;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: one expected entry per clock once stimulus is running
  // --------------------------------------------------------------------------
  exp_t mon_e;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks += 6;
      if (gnt !== mon_e.gnt) begin
        n_fail++;
        $display("FAIL gnt @%0t: got %b want %b", $time, gnt, mon_e.gnt);
      end
      if (ack !== mon_e.ack) begin
        n_fail++;
        $display("FAIL ack @%0t: got %b want %b", $time, ack, mon_e.ack);
      end
      if (q !== mon_e.q) begin
        n_fail++;
        $display("FAIL q @%0t: got %h want %h", $time, q, mon_e.q);
      end
      if (qbar !== ~mon_e.q) begin
        n_fail++;
        $display("FAIL qbar @%0t: got %h want %h", $time, qbar, ~mon_e.q);
      end
      if (busy !== mon_e.busy) begin
        n_fail++;
        $display("FAIL busy @%0t: got %b want %b", $time, busy, mon_e.busy);
      end
      if (!$onehot0(gnt)) begin
        n_fail++;
        $display("FAIL gnt_onehot @%0t: got %b want at most one bit", $time, gnt);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [NREQ-1:0] rr;

  initial begin
    reset = 1'b1;
    req   = '0;
    wr    = '0;
    wdata = '0;
    m_owner = -1;
    m_used  = 0;
    m_wait  = 0;
    m_last  = NREQ - 1;
    m_q     = '0;
    m_ack   = '0;

    // Reset state, then single requester write of A5
    cyc(1'b1, 4'b0000, 4'b0000, '0);
    cyc(1'b1, 4'b0000, 4'b0000, '0);
    cyc(1'b0, 4'b0001, 4'b0000, '0);
    cyc(1'b0, 4'b0001, 4'b0001, lane(0, 8'hA5));
    cyc(1'b0, 4'b0001, 4'b0000, '0);
    cyc(1'b0, 4'b0000, 4'b0000, '0);
    repeat (3) cyc(1'b0, 4'b0000, 4'b0000, '0);

    // All requesting: full tenures, order 0,1,2,3,0
    cyc(1'b1, 4'b0000, 4'b0000, '0);
    repeat (50) cyc(1'b0, 4'b1111, 4'b0000, '0);
    repeat (3) cyc(1'b0, 4'b0000, 4'b0000, '0);

    // Owner 2; non-owner write ignored; then owner writes 77
    cyc(1'b1, 4'b0000, 4'b0000, '0);
    cyc(1'b0, 4'b0100, 4'b0000, '0);
    cyc(1'b0, 4'b0100, 4'b0100, lane(2, 8'h11));
    cyc(1'b0, 4'b0110, 4'b0010, lane(1, 8'h3C));
    cyc(1'b0, 4'b0100, 4'b0000, '0);
    cyc(1'b0, 4'b0100, 4'b0100, lane(2, 8'h77));
    cyc(1'b0, 4'b0000, 4'b0000, '0);
    repeat (3) cyc(1'b0, 4'b0000, 4'b0000, '0);

    // Owner 0 writes F0 in its final grant cycle; requester 1 next
    cyc(1'b1, 4'b0000, 4'b0000, '0);
    cyc(1'b0, 4'b0011, 4'b0000, '0);
    repeat (MAX_HOLD - 1) cyc(1'b0, 4'b0011, 4'b0000, '0);
    cyc(1'b0, 4'b0011, 4'b0001, lane(0, 8'hF0));
    repeat (5) cyc(1'b0, 4'b0011, 4'b0000, '0);
    repeat (3) cyc(1'b0, 4'b0000, 4'b0000, '0);

    // Owner 3 interrupted by reset during a write; then 1010 grants 1
    cyc(1'b1, 4'b0000, 4'b0000, '0);
    cyc(1'b0, 4'b1000, 4'b0000, '0);
    cyc(1'b0, 4'b1000, 4'b0000, '0);
    cyc(1'b1, 4'b1000, 4'b1000, lane(3, 8'hEE));
    cyc(1'b0, 4'b1010, 4'b0000, '0);
    cyc(1'b0, 4'b1010, 4'b0000, '0);
    // Owner 1 writes, then drops req while strobing wr: no write
    cyc(1'b0, 4'b0010, 4'b0010, lane(1, 8'h5A));
    cyc(1'b0, 4'b0000, 4'b0010, lane(1, 8'h99));
    repeat (4) cyc(1'b0, 4'b0000, 4'b0000, '0);

    // Random traffic with sticky requests
    rr = '0;
    for (int n = 0; n < 3000; n++) begin
      logic            r;
      logic [NREQ-1:0] w;
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
      w = NREQ'($urandom);
      r = ($urandom_range(0, 199) == 0);
      cyc(r, rr, w, {$urandom});
    end
    cyc(1'b0, 4'b0000, 4'b0000, '0);

    // Drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
